// File: rtl/motor_pkg.sv
// motor_pkg
// Shared definitions for the motor command path (ramp limiter and PWM stage).
//   CMD_MAX / CMD_MIN : symmetric command range; -1024 is never produced so
//                       that negating a command can never overflow.
//   motor_cmd_t       : signed wheel command, same width as the PWM inputs.
//   chan_state_e      : per-wheel ramp state encoding.
package motor_pkg;

  localparam int CMD_W   = 11;
  localparam int CMD_MAX = 1023;
  localparam int CMD_MIN = -1023;

  typedef logic signed [CMD_W-1:0] motor_cmd_t;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_RAMP  = 2'd1,
    CH_DWELL = 2'd2
  } chan_state_e;

endpackage

// File: rtl/motor_ramp_chan.sv
// motor_ramp_chan
// One wheel of the slew-rate limiter. Holds the clamped target, the registered
// command and the last nonzero sign, and moves the command toward the target
// by at most one step per ramp tick. A reversal always parks the command at
// zero for one full tick (DWELL) before continuing in the new direction.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   tick         : one-cycle ramp tick from the shared prescaler
//   load         : latch target_raw (clamped) as the new target
//   brake        : emergency braking; target forced to 0, step scaled by 4
//   target_raw   : signed requested target
//   cmd          : signed registered command to the PWM stage
//   idle         : channel is at its target and not dwelling
module motor_ramp_chan
  import motor_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int STEP  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    load,
  input  logic                    brake,
  input  logic signed [WIDTH-1:0] target_raw,
  output logic signed [WIDTH-1:0] cmd,
  output logic                    idle
);

  // One extra bit so target - cmd can never overflow.
  localparam int DW = WIDTH + 1;

  chan_state_e             state, state_nxt;
  logic signed [WIDTH-1:0] tgt, tgt_clamped, tgt_eff, cmd_nxt;
  logic                    last_neg, last_neg_nxt;
  logic signed [DW-1:0]    diff, mag, step_sz, cand;
  logic                    dwell_cross;

  // Input clamp: only -1024 can fall outside the range at WIDTH=11, but the
  // upper bound is kept for wider builds.
  always_comb begin
    tgt_clamped = target_raw;
    if (int'(target_raw) < CMD_MIN)
      tgt_clamped = WIDTH'(CMD_MIN);
    else if (int'(target_raw) > CMD_MAX)
      tgt_clamped = WIDTH'(CMD_MAX);
  end

  // Target register. Braking clears it, so after the brake is released the
  // wheel stays at zero until a fresh target is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tgt <= '0;
    else if (brake)
      tgt <= '0;
    else if (load)
      tgt <= tgt_clamped;
  end

  // Braking acts in the same cycle it is asserted, not one cycle later.
  assign tgt_eff = brake ? '0 : tgt;

  // Step arithmetic. The candidate never passes the target: when the remaining
  // distance fits in one step the candidate is the target itself.
  always_comb begin
    diff    = DW'(tgt_eff) - DW'(cmd);
    mag     = diff[DW-1] ? -diff : diff;
    step_sz = brake ? DW'(4 * STEP) : DW'(STEP);
    if (mag <= step_sz)
      cand = DW'(tgt_eff);
    else if (diff[DW-1])
      cand = DW'(cmd) - step_sz;
    else
      cand = DW'(cmd) + step_sz;
  end

  // A reversal is detected only when moving off a nonzero command: starting
  // from rest in either direction needs no dwell. A zero target (including
  // braking) never dwells.
  assign dwell_cross = (cmd != '0) && (tgt_eff != '0) &&
                       (tgt_eff[WIDTH-1] != last_neg) &&
                       ((cand == '0) || (cand[DW-1] != last_neg));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CH_IDLE;
      cmd      <= '0;
      last_neg <= 1'b0;
    end else begin
      state    <= state_nxt;
      cmd      <= cmd_nxt;
      last_neg <= last_neg_nxt;
    end
  end

  // Next-state logic. IDLE also steps on a tick so that a target accepted just
  // before a tick moves the output on that tick without waiting a whole period
  // for the IDLE->RAMP transition.
  always_comb begin
    state_nxt    = state;
    cmd_nxt      = cmd;
    last_neg_nxt = last_neg;
    case (state)
      CH_IDLE, CH_RAMP: begin
        if (tick) begin
          if (dwell_cross) begin
            cmd_nxt   = '0;
            state_nxt = CH_DWELL;
          end else begin
            cmd_nxt = cand[WIDTH-1:0];
            if (cand != '0)
              last_neg_nxt = cand[DW-1];
            state_nxt = (cand == DW'(tgt_eff)) ? CH_IDLE : CH_RAMP;
          end
        end else if (tgt_eff != cmd) begin
          state_nxt = CH_RAMP;
        end
      end
      CH_DWELL: begin
        if (tick)
          state_nxt = CH_RAMP;
      end
      default: state_nxt = CH_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    idle = (state == CH_IDLE);
  end

endmodule

// File: rtl/motor_cmd_ramp.sv
// motor_cmd_ramp
// Slew-rate limiter in front of the PWM motor controller. Accepts a signed
// left/right target pair over valid/ready and ramps the registered lft/rht
// commands toward it by STEP per ramp tick (one tick every TICK_DIV clocks).
// Optional feature macro: MOTOR_RAMP_ESTOP_EN adds the estop input, which
// drops cmd_rdy, forces both targets to zero and brakes at 4*STEP per tick.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   cmd_lft, cmd_rht  : signed left/right targets
//   cmd_vld, cmd_rdy  : target handshake
//   estop             : emergency stop (MOTOR_RAMP_ESTOP_EN only)
//   lft, rht          : signed registered commands to the PWM stage
//   at_target         : both wheels at target and neither dwelling
module motor_cmd_ramp
  import motor_pkg::*;
#(
  parameter int WIDTH    = 11,
  parameter int STEP     = 4,
  parameter int TICK_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] cmd_lft,
  input  logic signed [WIDTH-1:0] cmd_rht,
  input  logic                    cmd_vld,
  output logic                    cmd_rdy,
`ifdef MOTOR_RAMP_ESTOP_EN
  input  logic                    estop,
`endif
  output logic signed [WIDTH-1:0] lft,
  output logic signed [WIDTH-1:0] rht,
  output logic                    at_target
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre;
  logic          tick;
  logic          accept;
  logic          brake;
  logic          lft_idle, rht_idle;

  // Ramp tick prescaler: counts 0..TICK_DIV-1, tick is high in the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pre <= '0;
    else if (tick)
      pre <= '0;
    else
      pre <= pre + 1'b1;
  end

  assign tick = (pre == PW'(TICK_DIV - 1));

`ifdef MOTOR_RAMP_ESTOP_EN
  assign brake = estop;
`else
  assign brake = 1'b0;
`endif

  assign cmd_rdy = ~brake;
  assign accept  = cmd_vld & cmd_rdy;

  motor_ramp_chan #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_lft (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (accept),
    .brake      (brake),
    .target_raw (cmd_lft),
    .cmd        (lft),
    .idle       (lft_idle)
  );

  motor_ramp_chan #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_rht (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (accept),
    .brake      (brake),
    .target_raw (cmd_rht),
    .cmd        (rht),
    .idle       (rht_idle)
  );

  assign at_target = lft_idle & rht_idle;

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// tb_motor_cmd_ramp
// Scoreboard bench for motor_cmd_ramp with TICK_DIV=4, STEP=4. Stimulus pushes
// the expected (lft, rht, at_target) for each upcoming ramp tick; a monitor
// pops one entry per tick, sampled on the falling edge after the update edge.
module tb_motor_cmd_ramp;
  import motor_pkg::*;

  localparam int TDIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  motor_cmd_t cmd_lft, cmd_rht;
  logic       cmd_vld;
  logic       cmd_rdy;
  motor_cmd_t lft, rht;
  logic       at_target;
`ifdef MOTOR_RAMP_ESTOP_EN
  logic       estop;
`endif

  typedef struct packed {
    motor_cmd_t l;
    motor_cmd_t r;
    logic       at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   popped   = 0;
  int   cyc;
  event tick_ev;

  motor_cmd_ramp #(
    .WIDTH    (11),
    .STEP     (4),
    .TICK_DIV (TDIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_lft   (cmd_lft),
    .cmd_rht   (cmd_rht),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
`ifdef MOTOR_RAMP_ESTOP_EN
    .estop     (estop),
`endif
    .lft       (lft),
    .rht       (rht),
    .at_target (at_target)
  );

  always #5 clk = ~clk;

  // Independent tick model: the DUT updates on every TDIV-th edge after reset.
  always @(posedge clk or posedge rst) begin
    if (rst)
      cyc <= 0;
    else
      cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst && cyc != 0 && (cyc % TDIV) == 0)
      -> tick_ev;
  end

  // Monitor: one scoreboard entry per ramp tick while entries are pending.
  initial begin
    forever begin
      @(tick_ev);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        popped++;
        checks++;
        if (lft !== mon_e.l || rht !== mon_e.r || at_target !== mon_e.at) begin
          failures++;
          $display("[TB] FAIL sb_tick#%0d got lft=%0d rht=%0d at=%0b expected lft=%0d rht=%0d at=%0b",
                   popped, lft, rht, at_target, $signed(mon_e.l), $signed(mon_e.r), mon_e.at);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic pushExp(input int l, input int r, input logic at);
    exp_t e;
    e.l  = motor_cmd_t'(l);
    e.r  = motor_cmd_t'(r);
    e.at = at;
    exp_q.push_back(e);
  endtask

  // Present one target pair right after a tick so the next tick uses it.
  task automatic applyStimulus(input int l, input int r);
    @(tick_ev);
    #1;
    cmd_lft = motor_cmd_t'(l);
    cmd_rht = motor_cmd_t'(r);
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_drain pending=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    cmd_lft = '0;
    cmd_rht = '0;
    cmd_vld = 1'b0;
`ifdef MOTOR_RAMP_ESTOP_EN
    estop = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("reset_lft", int'(lft), 0);
    checkOutput("reset_rht", int'(rht), 0);
    checkOutput("reset_at_target", int'(at_target), 1);
    checkOutput("reset_cmd_rdy", int'(cmd_rdy), 1);

    // From rest to (100, -102); right finishes one tick later with a step of 2.
    applyStimulus(100, -102);
    for (int k = 1; k <= 26; k++)
      pushExp((k <= 25) ? 4 * k : 100, (k <= 25) ? -4 * k : -102, k == 26);
    waitDrain("ramp_a", 26 * TDIV + 20);

    // Down to 8, then reverse to -8 with one tick held at zero.
    applyStimulus(8, -102);
    for (int k = 1; k <= 23; k++)
      pushExp(100 - 4 * k, -102, k == 23);
    waitDrain("ramp_down", 23 * TDIV + 20);
    applyStimulus(-8, -102);
    pushExp(4, -102, 1'b0);
    pushExp(0, -102, 1'b0);
    pushExp(0, -102, 1'b0);
    pushExp(-4, -102, 1'b0);
    pushExp(-8, -102, 1'b1);
    waitDrain("reverse_pos_neg", 5 * TDIV + 20);

    // Reverse back toward 100 (dwell again), then retarget to 20 at lft=40.
    applyStimulus(100, -102);
    pushExp(-4, -102, 1'b0);
    pushExp(0, -102, 1'b0);
    pushExp(0, -102, 1'b0);
    for (int k = 4; k <= 13; k++)
      pushExp(4 * (k - 3), -102, 1'b0);
    repeat (12) @(tick_ev);
    applyStimulus(20, -102);
    pushExp(36, -102, 1'b0);
    pushExp(32, -102, 1'b0);
    pushExp(28, -102, 1'b0);
    pushExp(24, -102, 1'b0);
    pushExp(20, -102, 1'b1);
    waitDrain("retarget", 5 * TDIV + 20);

    // Clamp: -1024 settles at -1023, after a dwell; right ramps to 0.
    applyStimulus(-1024, 0);
    for (int k = 1; k <= 262; k++) begin
      int l;
      if (k <= 5)
        l = 20 - 4 * k;
      else if (k == 6)
        l = 0;
      else
        l = (-4 * (k - 6) < -1023) ? -1023 : -4 * (k - 6);
      pushExp(l, (k <= 25) ? -102 + 4 * k : 0, k == 262);
    end
    waitDrain("clamp", 262 * TDIV + 20);

    // Targets without cmd_vld must be ignored.
    @(tick_ev);
    #1;
    cmd_lft = motor_cmd_t'(500);
    cmd_rht = motor_cmd_t'(77);
    for (int k = 1; k <= 3; k++)
      pushExp(-1023, 0, 1'b1);
    waitDrain("no_valid", 3 * TDIV + 20);

    // Accept in the tick cycle: that tick still uses the old target.
    @(tick_ev);
    #1;
    repeat (3) @(negedge clk);
    cmd_lft = motor_cmd_t'(-1000);
    cmd_rht = motor_cmd_t'(0);
    cmd_vld = 1'b1;
    pushExp(-1023, 0, 1'b1);
    for (int k = 2; k <= 6; k++)
      pushExp(-1023 + 4 * (k - 1), 0, 1'b0);
    pushExp(-1000, 0, 1'b1);
    @(negedge clk);
    cmd_vld = 1'b0;
    waitDrain("accept_on_tick", 7 * TDIV + 20);

`ifdef MOTOR_RAMP_ESTOP_EN
    // Brake from -1000 at 16 per tick, then stay at zero after release.
    @(tick_ev);
    #1;
    estop = 1'b1;
    #1;
    checkOutput("estop_cmd_rdy", int'(cmd_rdy), 0);
    for (int k = 1; k <= 63; k++)
      pushExp((k <= 62) ? -1000 + 16 * k : 0, 0, k == 63);
    waitDrain("estop_brake", 63 * TDIV + 20);
    @(tick_ev);
    #1;
    estop = 1'b0;
    #1;
    checkOutput("estop_release_cmd_rdy", int'(cmd_rdy), 1);
    for (int k = 1; k <= 3; k++)
      pushExp(0, 0, 1'b1);
    waitDrain("estop_release", 3 * TDIV + 20);
`endif

    // Reset in the middle of a ramp clears everything without waiting a clock.
    applyStimulus(200, 200);
    repeat (3) @(tick_ev);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midramp_reset_lft", int'(lft), 0);
    checkOutput("midramp_reset_rht", int'(rht), 0);
    checkOutput("midramp_reset_at_target", int'(at_target), 1);
    checkOutput("midramp_reset_cmd_rdy", int'(cmd_rdy), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motor_cmd_ramp.md
# motor_cmd_ramp

Slew-rate limiter that sits directly upstream of the PWM motor controller. Accepts signed left/right speed targets through a valid/ready handshake and ramps the registered `lft`/`rht` commands toward them at a fixed step per ramp tick, so the PWM stage never sees a step change or an instant direction reversal. Each wheel ramps independently, with a one-tick dwell at zero on reversal.

## Interface
- `WIDTH`, 11, signed command width; must match the PWM stage `lft`/`rht` width.
- `STEP`, 4, magnitude change per ramp tick (unsigned, 1..511).
- `TICK_DIV`, 1000, clocks per ramp tick (>= 2).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_lft`  in  WIDTH  signed left target.
- `cmd_rht`  in  WIDTH  signed right target.
- `cmd_vld`  in  1  target pair valid.
- `cmd_rdy`  out  1  block can accept a target pair.
- `lft`  out  WIDTH  signed left command to the PWM stage (registered).
- `rht`  out  WIDTH  signed right command to the PWM stage (registered).
- `at_target`  out  1  both channels equal their targets and neither is dwelling.
- `estop`  in  1  emergency stop (present only with `MOTOR_RAMP_ESTOP_EN`).

## Operation
- Accept on `cmd_vld && cmd_rdy`. Both targets latch on that edge. Each target is clamped to [-1023, +1023], so -1024 becomes -1023. A new accept overwrites any ramp in progress.
- Prescaler counts 0..TICK_DIV-1 and wraps. `tick` pulses for one cycle on the wrap. Channels update only on `tick`.
- Per-channel state machine:
  - **IDLE**: current == target.
    - If target != current, go to RAMP.
  - **RAMP**, on each tick:
    - diff = target - current, computed at WIDTH+1 bits.
    - If |diff| <= STEP, current := target.
    - Otherwise current += sign(diff)*STEP.
    - If the update would cross zero, current := 0 instead and the channel goes to DWELL.
    - When current == target, go to IDLE.
  - **DWELL**: hold 0 for exactly one tick, then go to RAMP.
    - Entered when current reaches 0, target sign is opposite to the last nonzero sign of current, and target != 0.
- The last nonzero sign is tracked per channel. Reset value is positive.
- `at_target` = both channels in IDLE.
- Without the estop feature, `cmd_rdy` is constant 1.

## Timing
- Reset values:
  - `lft` = `rht` = 0.
  - targets = 0.
  - prescaler = 0.
  - both channels IDLE.
  - `at_target` = 1.
  - `cmd_rdy` = 1.
- A target accepted in cycle N is visible to channel logic in N+1. The first output change occurs on the first tick at or after N+1.
- Tick and accept in the same cycle: the update uses the old target. The new target applies from the next tick.
- Outputs change only on the clock edge following a tick. Worst-case latency 0→±1023 with STEP=4: 256 ticks.
- Reset asserted mid-ramp: everything returns to reset values immediately, with no ramp-down.

## Configuration
- `MOTOR_RAMP_ESTOP_EN` defined:
  - Adds the `estop` port.
  - While `estop` = 1: `cmd_rdy` = 0, both targets are forced to 0, and the step becomes 4*STEP, saturating at the distance to 0.
  - DWELL does not apply when braking to zero.
  - After `estop` falls, targets stay 0 until a new accept.
- Not defined: no `estop` port, `cmd_rdy` tied 1, single step size.

## Structure
- Shared package `motor_pkg` holds:
  - `CMD_MAX` = 1023 and `CMD_MIN` = -1023.
  - the channel state encoding (IDLE, RAMP, DWELL).
  - the signed command typedef of WIDTH bits, shared with the PWM stage.
- Sub-module `motor_ramp_chan`:
  - one per wheel, instantiated twice.
  - contains the per-channel state machine, clamp, step arithmetic and last-sign register.
- The prescaler, handshake and estop gating live in the top level.

## Test plan
All scenarios use TICK_DIV=4 and STEP=4.
- Reset, then idle for 20 clocks → `lft`=`rht`=0, `at_target`=1, `cmd_rdy`=1.
- Accept (100, -102) → `lft` steps 4, 8, … and reaches 100 after 25 ticks. `rht` reaches -102 after 26 ticks, with a final step of 2. `at_target` rises only once both are done.
- From `lft`=8, accept `lft`=-8 → 8, 4, 0, then 0 held one extra tick (DWELL), then -4, -8.
- Accept target -1024 → `lft` settles at -1023. Accept +2000 via sign-extended overflow wrap is not applicable: the input is WIDTH bits, so the clamp test uses -1024 only.
- Mid-ramp at `lft`=40 toward 100, accept 20 → next tick 36, ramping down to 20, with no overshoot.
- With `MOTOR_RAMP_ESTOP_EN`: at `lft`=100, assert `estop` → `cmd_rdy`=0, `lft` goes 84, 68, … reaching 0 in 7 ticks. Release `estop` → `lft` stays 0 until a new accept.
